// File: rtl/spgd_seq.sv
// SPGD iteration sequencer: drives +sigma / -sigma perturbation phases, averages the
// photodetector metric in each phase and reports DJ = J_plus - J_minus per iteration.
module spgd_seq #(
   parameter int ADC_WIDTH    = 12,
   parameter int MAX_AVE_LOG2 = 10,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                                       ADC_CLK,
   input  logic                                       RST_N,
   input  logic                                       TRIG_IN,
   input  logic                                       ENABLE,
   input  logic        [CNT_WIDTH-1:0]                SETTLE_CYCLES,
   input  logic        [3:0]                          AVE_LOG2,
   input  logic signed [ADC_WIDTH-1:0]                METRIC_IN,
   output logic        [1:0]                          PERT_SIGN,
   output logic signed [ADC_WIDTH+MAX_AVE_LOG2:0]     DJ,
   output logic                                       DJ_VALID,
   output logic                                       BUSY,
   output logic        [CNT_WIDTH-1:0]                ITER_CNT,
   output logic                                       OVERRUN
);

   localparam int ACC_W = ADC_WIDTH + MAX_AVE_LOG2;
   localparam int DJ_W  = ACC_W + 1;
   localparam int CW    = (CNT_WIDTH > MAX_AVE_LOG2 + 1) ? CNT_WIDTH : MAX_AVE_LOG2 + 1;
   localparam logic [3:0] MAX_L = 4'(MAX_AVE_LOG2);

   typedef enum logic [2:0] {
      IDLE, SETTLE_P, ACQ_P, SETTLE_M, ACQ_M, DONE
   } state_t;

   state_t state, state_nxt;

   logic                    trig_p0, trig_p1, trig_p2;
   logic                    trig_edge;
   logic [CW-1:0]           cnt;
   logic [CNT_WIDTH-1:0]    s_lat;
   logic [3:0]              l_lat;
   logic signed [ACC_W-1:0] acc, acc_sum, j_plus, metric_ext;
   logic signed [DJ_W-1:0]  dj_nxt;

   function automatic logic [3:0] sat_log2(input logic [3:0] v);
      return (v > MAX_L) ? MAX_L : v;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] settle_len(input logic [CNT_WIDTH-1:0] s);
      return (s == '0) ? CNT_WIDTH'(1) : s;
   endfunction

   // Trigger synchronizer (p0, p1) plus history flop (p2) for rising-edge detect
   always_ff @(posedge ADC_CLK or negedge RST_N) begin
      if (!RST_N) begin
         trig_p0 <= 1'b0;
         trig_p1 <= 1'b0;
         trig_p2 <= 1'b0;
      end else begin
         trig_p0 <= TRIG_IN;
         trig_p1 <= trig_p0;
         trig_p2 <= trig_p1;
      end
   end

   assign trig_edge = trig_p1 & ~trig_p2;

   always_ff @(posedge ADC_CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state != IDLE && !ENABLE) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:     if (trig_edge && ENABLE) state_nxt = SETTLE_P;
            SETTLE_P: if (cnt == CW'(1)) state_nxt = ACQ_P;
            ACQ_P:    if (cnt == CW'(1)) state_nxt = SETTLE_M;
            SETTLE_M: if (cnt == CW'(1)) state_nxt = ACQ_M;
            ACQ_M:    if (cnt == CW'(1)) state_nxt = DONE;
            default:  state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      PERT_SIGN = 2'b00;
      BUSY      = 1'b1;
      DJ_VALID  = 1'b0;
      case (state)
         IDLE:            BUSY      = 1'b0;
         SETTLE_P, ACQ_P: PERT_SIGN = 2'b01;
         SETTLE_M, ACQ_M: PERT_SIGN = 2'b10;
         DONE:            DJ_VALID  = 1'b1;
         default:         PERT_SIGN = 2'b00;
      endcase
   end

   assign metric_ext = {{MAX_AVE_LOG2{METRIC_IN[ADC_WIDTH-1]}}, METRIC_IN};
   assign acc_sum    = acc + metric_ext;
   assign dj_nxt     = {j_plus[ACC_W-1], j_plus} - {acc_sum[ACC_W-1], acc_sum};

   // Phase counter counts down to 1; it is reloaded on every state change
   always_ff @(posedge ADC_CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt      <= '0;
         s_lat    <= '0;
         l_lat    <= '0;
         acc      <= '0;
         j_plus   <= '0;
         DJ       <= '0;
         ITER_CNT <= '0;
         OVERRUN  <= 1'b0;
      end else begin
         if (trig_edge && state != IDLE) OVERRUN <= 1'b1;

         if (state == IDLE && state_nxt == SETTLE_P) begin
            s_lat <= SETTLE_CYCLES;
            l_lat <= sat_log2(AVE_LOG2);
         end

         if (state_nxt != state) begin
            case (state_nxt)
               SETTLE_P:     cnt <= CW'(settle_len(SETTLE_CYCLES));
               SETTLE_M:     cnt <= CW'(settle_len(s_lat));
               ACQ_P, ACQ_M: cnt <= CW'(1) << l_lat;
               default:      cnt <= '0;
            endcase
         end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
         end

         if ((state_nxt == ACQ_P || state_nxt == ACQ_M) && state_nxt != state)
            acc <= '0;
         else if (state == ACQ_P || state == ACQ_M)
            acc <= acc_sum;

         if (state == ACQ_P && state_nxt == SETTLE_M) j_plus <= acc_sum;

         if (state == ACQ_M && state_nxt == DONE) begin
            DJ       <= dj_nxt;
            ITER_CNT <= ITER_CNT + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_spgd_seq.sv
// Randomized scoreboard bench for spgd_seq: iterations are scheduled from the published
// phase lengths, expected DJ / ITER_CNT are queued and checked whenever DJ_VALID strobes.
module tb_spgd_seq;

   localparam int AW = 12;
   localparam int ML = 10;
   localparam int CW = 16;
   localparam int DW = AW + ML + 1;

   logic                 ADC_CLK;
   logic                 RST_N;
   logic                 TRIG_IN;
   logic                 ENABLE;
   logic        [CW-1:0] SETTLE_CYCLES;
   logic        [3:0]    AVE_LOG2;
   logic signed [AW-1:0] METRIC_IN;
   logic        [1:0]    PERT_SIGN;
   logic signed [DW-1:0] DJ;
   logic                 DJ_VALID;
   logic                 BUSY;
   logic        [CW-1:0] ITER_CNT;
   logic                 OVERRUN;

   spgd_seq #(.ADC_WIDTH(AW), .MAX_AVE_LOG2(ML), .CNT_WIDTH(CW)) dut (
      .ADC_CLK(ADC_CLK), .RST_N(RST_N), .TRIG_IN(TRIG_IN), .ENABLE(ENABLE),
      .SETTLE_CYCLES(SETTLE_CYCLES), .AVE_LOG2(AVE_LOG2), .METRIC_IN(METRIC_IN),
      .PERT_SIGN(PERT_SIGN), .DJ(DJ), .DJ_VALID(DJ_VALID), .BUSY(BUSY),
      .ITER_CNT(ITER_CNT), .OVERRUN(OVERRUN)
   );

   typedef struct {
      longint dj;
      longint iter;
   } exp_t;

   exp_t   sb_q[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   longint model_iter = 0;
   longint model_dj   = 0;
   longint model_ovr  = 0;

   initial begin
      ADC_CLK = 1'b0;
      forever #5 ADC_CLK = ~ADC_CLK;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got no summary, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every DJ_VALID strobe must match the oldest queued expectation
   always @(negedge ADC_CLK) begin
      exp_t e;
      if (RST_N === 1'b1 && DJ_VALID === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_dj_valid", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("dj", DJ, e.dj);
            check("iter_cnt_at_done", ITER_CNT, e.iter);
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_pert"},     PERT_SIGN, 0);
      check({tag, "_dj"},       DJ,        0);
      check({tag, "_dj_valid"}, DJ_VALID,  0);
      check({tag, "_busy"},     BUSY,      0);
      check({tag, "_iter_cnt"}, ITER_CNT,  0);
      check({tag, "_overrun"},  OVERRUN,   0);
   endtask

   // mode: 0 normal, 1 retrigger in ACQ_M, 2 ENABLE drop in SETTLE_M,
   //       3 reset in mid ACQ_P, 4 retrigger landing in DONE
   // pat:  0 random metric, 1 100/40 pair, 2 -2048/+2047 extremes
   task automatic run_iter(input int s, input int l, input int mode, input int pat);
      int     se, le, n, len, stop_at, exp_p;
      longint jp, jm;
      logic signed [AW-1:0] samp[];
      se  = (s == 0) ? 1 : s;
      le  = (l > ML) ? ML : l;
      n   = 1 << le;
      len = 2 * se + 2 * n + 1;
      samp = new[len];
      jp = 0;
      jm = 0;
      for (int i = 0; i < len; i++) begin
         case (pat)
            1:       samp[i] = (i < se + n) ? AW'(100)   : AW'(40);
            2:       samp[i] = (i < se + n) ? AW'(-2048) : AW'(2047);
            default: samp[i] = AW'($urandom);
         endcase
         if (i >= se && i < se + n)             jp += samp[i];
         if (i >= 2 * se + n && i < 2 * se + 2 * n) jm += samp[i];
      end
      if (mode == 0 || mode == 1 || mode == 4) begin
         model_iter = (model_iter + 1) % 65536;
         model_dj   = jp - jm;
         sb_q.push_back('{model_dj, model_iter});
      end
      stop_at = (mode == 2) ? se + n : ((mode == 3) ? se + n / 2 : len);

      TRIG_IN = 1'b0;
      repeat (4) @(negedge ADC_CLK);
      SETTLE_CYCLES = CW'(s);
      AVE_LOG2      = 4'(l);
      ENABLE        = 1'b1;
      TRIG_IN       = 1'b1;
      repeat (3) @(posedge ADC_CLK);

      for (int i = 0; i < stop_at; i++) begin
         @(negedge ADC_CLK);
         METRIC_IN = samp[i];
         if (i == 0) begin
            check("overrun_before", OVERRUN, model_ovr);
            TRIG_IN       = 1'b0;
            SETTLE_CYCLES = CW'($urandom);
            AVE_LOG2      = 4'($urandom);
         end
         if (mode == 1 && i == 2 * se + n) TRIG_IN = 1'b1;
         if (mode == 4 && i == len - 3)    TRIG_IN = 1'b1;
         exp_p = (i < se + n) ? 1 : ((i < 2 * se + 2 * n) ? 2 : 0);
         check($sformatf("pert_sign[%0d]", i), PERT_SIGN, exp_p);
         check($sformatf("busy[%0d]", i), BUSY, 1);
      end

      if (mode == 2) begin
         @(negedge ADC_CLK);
         check("pert_at_drop", PERT_SIGN, 2);
         ENABLE = 1'b0;
         @(negedge ADC_CLK);
         check("busy_after_drop", BUSY, 0);
         check("pert_after_drop", PERT_SIGN, 0);
         check("dj_after_drop", DJ, model_dj);
         check("iter_after_drop", ITER_CNT, model_iter);
         ENABLE = 1'b1;
      end else if (mode == 3) begin
         @(negedge ADC_CLK);
         RST_N = 1'b0;
         #1;
         check_reset_vals("midrst");
         model_iter = 0;
         model_dj   = 0;
         model_ovr  = 0;
         sb_q.delete();
         repeat (2) @(negedge ADC_CLK);
         RST_N = 1'b1;
      end else begin
         if (mode == 1 || mode == 4) model_ovr = 1;
         @(negedge ADC_CLK);
         check("busy_after", BUSY, 0);
         check("pert_after", PERT_SIGN, 0);
         check("dj_valid_after", DJ_VALID, 0);
         check("dj_held", DJ, model_dj);
         check("iter_cnt", ITER_CNT, model_iter);
         check("overrun", OVERRUN, model_ovr);
         if (mode == 1 || mode == 4) begin
            repeat (4) begin
               @(negedge ADC_CLK);
               check("no_restart_busy", BUSY, 0);
            end
         end
      end
   endtask

   task automatic idle_trig_disabled();
      TRIG_IN = 1'b0;
      repeat (4) @(negedge ADC_CLK);
      ENABLE  = 1'b0;
      TRIG_IN = 1'b1;
      repeat (6) begin
         @(negedge ADC_CLK);
         check("disabled_busy", BUSY, 0);
      end
      check("disabled_overrun", OVERRUN, model_ovr);
      TRIG_IN = 1'b0;
      repeat (4) @(negedge ADC_CLK);
      ENABLE = 1'b1;
   endtask

   initial begin
      RST_N         = 1'b0;
      TRIG_IN       = 1'b0;
      ENABLE        = 1'b0;
      SETTLE_CYCLES = '0;
      AVE_LOG2      = '0;
      METRIC_IN     = '0;
      repeat (3) @(negedge ADC_CLK);
      check_reset_vals("reset");
      RST_N = 1'b1;

      run_iter(4, 2, 0, 1);
      run_iter(0, 0, 0, 0);
      run_iter(1, 10, 0, 2);
      for (int k = 0; k < 4; k++)
         run_iter(int'($urandom_range(0, 12)), int'($urandom_range(0, 4)), 0, 0);
      idle_trig_disabled();
      run_iter(5, 3, 2, 0);
      run_iter(3, 2, 1, 0);
      run_iter(2, 15, 0, 0);
      run_iter(3, 15, 3, 0);
      run_iter(3, 2, 4, 0);
      run_iter(2, 1, 0, 1);

      repeat (2) @(negedge ADC_CLK);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spgd_seq.md
SPGD_SEQ -- requirements
Module: spgd_seq

Interface
REQ-001 SHALL have parameter ADC_WIDTH, default 12, metric sample width (signed two's complement).
REQ-002 SHALL have parameter MAX_AVE_LOG2, default 10, maximum log2 of samples averaged per half-iteration.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, settle-counter and iteration-counter width.
REQ-004 SHALL have port ADC_CLK  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port RST_N  input  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port TRIG_IN  input  1  asynchronous iteration trigger; rising edge starts an iteration.
REQ-007 SHALL have port ENABLE  input  1  run enable; low aborts and holds IDLE.
REQ-008 SHALL have port SETTLE_CYCLES  input  CNT_WIDTH  cycles to wait after each perturbation change.
REQ-009 SHALL have port AVE_LOG2  input  4  log2 of samples accumulated per half-iteration.
REQ-010 SHALL have port METRIC_IN  input  ADC_WIDTH  signed calibrated photodetector metric sample.
REQ-011 SHALL have port PERT_SIGN  output  2  perturbation command: 00 none, 01 +sigma, 10 -sigma; 11 never driven.
REQ-012 SHALL have port DJ  output  ADC_WIDTH+MAX_AVE_LOG2+1  signed J_plus minus J_minus.
REQ-013 SHALL have port DJ_VALID  output  1  one-cycle strobe qualifying DJ.
REQ-014 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-015 SHALL have port ITER_CNT  output  CNT_WIDTH  completed-iteration count.
REQ-016 SHALL have port OVERRUN  output  1  sticky; a trigger edge arrived while BUSY.

Function
REQ-017 TRIG_IN SHALL pass through a two-flop synchronizer plus one history flop; edge = sync2 & ~hist.
REQ-018 If TRIG_IN is first sampled high at edge k, state SHALL leave IDLE and PERT_SIGN SHALL become 01 at edge k+2.
REQ-019 States SHALL be IDLE, SETTLE_P, ACQ_P, SETTLE_M, ACQ_M, DONE, in that order; DONE returns to IDLE.
REQ-020 IDLE -> SETTLE_P only on edge with ENABLE=1; edges with ENABLE=0 in IDLE are ignored, no flag.
REQ-021 SETTLE_CYCLES and AVE_LOG2 SHALL be latched on the IDLE->SETTLE_P transition; mid-iteration changes ignored.
REQ-022 Latched AVE_LOG2 greater than MAX_AVE_LOG2 SHALL be clamped to MAX_AVE_LOG2.
REQ-023 Each SETTLE state SHALL last exactly S cycles, S = latched SETTLE_CYCLES, S=0 treated as 1.
REQ-024 Each ACQ state SHALL last exactly N = 2^L cycles, accumulating METRIC_IN sign-extended each cycle.
REQ-025 Accumulator SHALL be ADC_WIDTH+MAX_AVE_LOG2 bits, cleared on entry to each ACQ state; no overflow possible.
REQ-026 PERT_SIGN SHALL be 01 in SETTLE_P/ACQ_P, 10 in SETTLE_M/ACQ_M, 00 in IDLE/DONE.
REQ-027 DONE SHALL last one cycle; DJ = J_plus - J_minus registered, DJ_VALID=1, ITER_CNT increments in that cycle.
REQ-028 DJ SHALL hold its value until the next DONE; ITER_CNT SHALL wrap from all-ones to 0.
REQ-029 Iteration length SHALL be 2S+2N+1 cycles from leaving IDLE to returning to IDLE.
REQ-030 Trigger edge detected while BUSY SHALL set OVERRUN and SHALL NOT queue or restart; OVERRUN clears only on reset.
REQ-031 Trigger edge in the same cycle as DONE SHALL count as overrun (DONE is BUSY).
REQ-032 ENABLE=0 in any non-IDLE state SHALL go to IDLE next edge: PERT_SIGN=00, no DJ_VALID, ITER_CNT, DJ unchanged.
REQ-033 ENABLE low and trigger edge in the same IDLE cycle: trigger ignored.

Reset
REQ-034 While RST_N=0: state IDLE, PERT_SIGN=00, DJ=0, DJ_VALID=0, BUSY=0, ITER_CNT=0, OVERRUN=0, accumulators and synchronizer flops 0.
REQ-035 Reset asserted mid-iteration SHALL abort immediately; first trigger edge after release starts a fresh iteration.

Verification
REQ-036 S=4, AVE_LOG2=2, METRIC=100 while PERT=01, 40 while PERT=10 -> DJ=240, DJ_VALID one cycle, BUSY 17 cycles, ITER_CNT=1.
REQ-037 METRIC=-2048 in ACQ_P, +2047 in ACQ_M, AVE_LOG2=10 -> DJ=-4193280, no wrap.
REQ-038 SETTLE_CYCLES=0, AVE_LOG2=0 -> BUSY exactly 5 cycles, PERT 01,01,10,10,00.
REQ-039 Second TRIG_IN rise during ACQ_M -> OVERRUN=1, iteration completes normally, no second iteration starts.
REQ-040 ENABLE dropped in SETTLE_M -> IDLE next cycle, PERT_SIGN=00, DJ_VALID never pulses, ITER_CNT unchanged.
REQ-041 AVE_LOG2=15 with MAX_AVE_LOG2=10 -> each ACQ lasts 1024 cycles; RST_N pulsed mid-ACQ_P -> all outputs at reset values.
